// File: rtl/grass_pkg.sv
// ============================================================================
// Module : grass_pkg
// Shared types and defaults for the GRASS round controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package grass_pkg;

   localparam int BLOCK_W        = 128;
   localparam int NUM_ROUNDS_DEF = 10;
   localparam int STAGE_LAT_DEF  = 17;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } grass_state_e;

endpackage : grass_pkg

`default_nettype wire

// File: rtl/grass_lat_timer.sv
// ============================================================================
// Module : grass_lat_timer
// Loadable down-counter with a zero flag, used to time the shared stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module grass_lat_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clear_i) begin
         r_count <= '0;
      end else if (load_i) begin
         r_count <= load_val_i;
      end else if (en_i && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign zero_o = (r_count == '0);

endmodule : grass_lat_timer

`default_nettype wire

// File: rtl/grass_round_ctrl.sv
// ============================================================================
// Module : grass_round_ctrl
// Iterates one block NUM_ROUNDS times through an external fixed-latency stage.
// Optional feature macro: GRASS_PERF_CNT_EN (block and busy-cycle counters).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module grass_round_ctrl
   import grass_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter int STAGE_LAT  = STAGE_LAT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [BLOCK_W-1:0] in_data_i,
   input  logic               flush_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [BLOCK_W-1:0] out_data_o,
   output logic [3:0]         stage_num_o,
   output logic [BLOCK_W-1:0] stage_data_o,
   input  logic [BLOCK_W-1:0] stage_data_i
`ifdef GRASS_PERF_CNT_EN
   ,
   output logic [31:0]        blocks_done_o,
   output logic [31:0]        busy_cycles_o
`endif
);

   localparam int               c_CNT_W      = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
   localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(STAGE_LAT - 1);
   localparam logic [3:0]       c_LAST_ROUND = 4'(NUM_ROUNDS - 1);

   grass_state_e       r_state;
   grass_state_e       w_state_next;
   logic               r_in_ready;
   logic [BLOCK_W-1:0] r_work;
   logic [3:0]         r_round;
   logic               w_accept;
   logic               w_out_hs;
   logic               w_load;
   logic               w_capture;
   logic               w_abort;
   logic               w_lat_zero;

   assign w_accept = in_valid_i && r_in_ready;
   assign w_out_hs = out_valid_o && out_ready_i;

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_capture    = 1'b0;
      w_abort      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_load       = 1'b1;
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_lat_zero) begin
               w_capture    = 1'b1;
               w_state_next = (r_round == c_LAST_ROUND) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE: begin
            if (w_out_hs) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
      // Abort wins over any capture so a stale stage result never lands in work
      if (flush_i && (r_state != ST_IDLE)) begin
         w_abort      = 1'b1;
         w_load       = 1'b0;
         w_capture    = 1'b0;
         w_state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= (w_state_next == ST_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_work  <= '0;
         r_round <= '0;
      end else if (w_abort) begin
         r_round <= '0;
      end else if (w_accept) begin
         r_work  <= in_data_i;
         r_round <= '0;
      end else if (w_capture) begin
         r_work <= stage_data_i;
         if (r_round != c_LAST_ROUND) r_round <= r_round + 4'd1;
      end
   end

   grass_lat_timer #(
      .CNT_W (c_CNT_W)
   ) u_lat_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (w_load),
      .clear_i    (w_abort),
      .en_i       (r_state == ST_WAIT),
      .load_val_i (c_LAT_LOAD),
      .zero_o     (w_lat_zero)
   );

   assign in_ready_o   = r_in_ready;
   assign out_valid_o  = (r_state == ST_DONE) && !flush_i;
   assign out_data_o   = r_work;
   assign stage_num_o  = r_round;
   assign stage_data_o = r_work;

`ifdef GRASS_PERF_CNT_EN
   logic [31:0] r_blocks_done;
   logic [31:0] r_busy_cycles;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_blocks_done <= '0;
         r_busy_cycles <= '0;
      end else begin
         if (w_out_hs) r_blocks_done <= r_blocks_done + 32'd1;
         if ((r_state != ST_IDLE) && (r_busy_cycles != 32'hFFFF_FFFF))
            r_busy_cycles <= r_busy_cycles + 32'd1;
      end
   end

   assign blocks_done_o = r_blocks_done;
   assign busy_cycles_o = r_busy_cycles;
`else
   // This build carries no performance counters.
`endif

endmodule : grass_round_ctrl

`default_nettype wire

// File: tb/tb_grass_round_ctrl.sv
// ============================================================================
// Module : tb_grass_round_ctrl
// Directed bench for grass_round_ctrl with a fixed-latency stub stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_grass_round_ctrl;

   localparam int STAGE_LAT = 17;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   stage_num;
   logic [127:0] stage_data_o;
   logic [127:0] stage_data_i;
`ifdef GRASS_PERF_CNT_EN
   logic [31:0]  blocks_done;
   logic [31:0]  busy_cycles;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   grass_round_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .flush_i      (flush),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .stage_num_o  (stage_num),
      .stage_data_o (stage_data_o),
      .stage_data_i (stage_data_i)
`ifdef GRASS_PERF_CNT_EN
      ,
      .blocks_done_o (blocks_done),
      .busy_cycles_o (busy_cycles)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Stub stage: input + round + 1, fed every cycle so stale values flow through
   logic [127:0] pipe [STAGE_LAT];
   always @(posedge clk) begin
      pipe[0] <= stage_data_o + 128'(stage_num) + 128'd1;
      for (int i = 1; i < STAGE_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign stage_data_i = pipe[STAGE_LAT-1];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns the cycle in which the handshake is seen.
   task automatic send(input logic [127:0] d, output int acc);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("send_ready_timeout", 128'(in_ready), 128'd1);
      acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Returns the cycle in which out_valid is first seen high.
   task automatic wait_out(output int d);
      int n;
      n = 0;
      while (!out_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_timeout", 128'(out_valid), 128'd1);
      d = cyc;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_valid_drop", 128'(out_valid), 128'd0);
      check("hs_ready_back", 128'(in_ready), 128'd1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_in_ready"},   128'(in_ready),  128'd0);
      check({pfx, "_out_valid"},  128'(out_valid), 128'd0);
      check({pfx, "_out_data"},   out_data,        128'd0);
      check({pfx, "_stage_num"},  128'(stage_num), 128'd0);
      check({pfx, "_stage_data"}, stage_data_o,    128'd0);
   endtask

   initial begin
      int acc, acc2, d, d2, n;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_release", 128'(in_ready), 128'd1);

      // Block 0 -> 55, latency 181, stall 20 cycles
      send(128'd0, acc);
      wait_out(d);
      check("lat_blk0", 128'(d - acc), 128'd181);
      check("data_blk0", out_data, 128'd55);
      in_valid = 1'b1;
      in_data  = 128'hDEAD;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall_valid", 128'(out_valid), 128'd1);
         check("stall_data",  out_data,        128'd55);
         check("stall_ready", 128'(in_ready),  128'd0);
      end
      in_valid = 1'b0;
      handshake();

      // Flush during round 4 WAIT, then 0x100 -> 0x137
      send(128'h55AA, acc);
      n = 0;
      while (stage_num != 4'd4 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("reach_round4", 128'(stage_num), 128'd4);
      repeat (5) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_valid", 128'(out_valid), 128'd0);
      check("flush_ready", 128'(in_ready),  128'd1);
      send(128'h100, acc);
      wait_out(d);
      check("lat_flush", 128'(d - acc), 128'd181);
      check("data_flush", out_data, 128'h137);
      handshake();

      // Reset mid-block at cycle 90, then 0x300 -> 0x337
      send(128'h200, acc);
      n = 0;
      while (cyc < acc + 90 && n < 400) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst90");
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_rst90", 128'(in_ready), 128'd1);
      send(128'h300, acc);
      wait_out(d);
      check("lat_rst", 128'(d - acc), 128'd181);
      check("data_rst", out_data, 128'h337);
      handshake();

      // Back-to-back with out_ready held high
      rst = 1'b0;
      @(negedge clk);
`ifdef GRASS_PERF_CNT_EN
      check("perf_rst_blocks", 128'(blocks_done), 128'd0);
      check("perf_rst_busy",   128'(busy_cycles), 128'd0);
`endif
      rst = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      send(128'h10, acc);
      wait_out(d);
      check("lat_b2b1", 128'(d - acc), 128'd181);
      check("data_b2b1", out_data, 128'h47);
      send(128'h20, acc2);
      check("b2b_accept_gap", 128'(acc2 + 1 - d), 128'd2);
      wait_out(d2);
      check("lat_b2b2", 128'(d2 - acc2), 128'd181);
      check("data_b2b2", out_data, 128'h57);
      @(negedge clk);
      out_ready = 1'b0;
      check("b2b_valid_drop", 128'(out_valid), 128'd0);
`ifdef GRASS_PERF_CNT_EN
      check("perf_blocks", 128'(blocks_done), 128'd2);
      check("perf_busy",   128'(busy_cycles), 128'd362);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_grass_round_ctrl

`default_nettype wire
